jtframe_dual_ram_bclr: RTL and testbench

//  Single-clock true dual-port RAM. Successor to the plain dual-port RAM, adding:
//   - per-byte write enables;
//   - selectable read-during-write mode;
//   - 1- or 2-cycle read latency, with a read-valid strobe;
//   - a built-in clear engine that fills memory with CLRVAL after reset or on request.

---
 rtl/jtframe_dual_ram_bclr.sv | 161 ++++++++++++++++
 tb/tb_jtframe_dual_ram_bclr.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dual_ram_bclr.sv
// Single-clock true dual-port RAM with per-byte write enables, selectable
// read-during-write behaviour, 1- or 2-cycle read latency with a valid strobe,
// and a clear engine that fills the whole array with CLRVAL.
module jtframe_dual_ram_bclr #(
  parameter int DW         = 16,
  parameter int AW         = 10,
  parameter int LAT        = 1,
  parameter int RDW        = 0,
  parameter int CLR_ON_RST = 1,
  parameter logic [DW-1:0] CLRVAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            busy,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   data0,
  input  logic [DW/8-1:0] we0,
  input  logic            rd0,
  output logic [DW-1:0]   q0,
  output logic            qv0,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   data1,
  input  logic [DW/8-1:0] we1,
  input  logic            rd1,
  output logic [DW-1:0]   q1,
  output logic            qv1
);

  localparam int BW = DW / 8;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          st, st_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   mem [2**AW];

  logic            same_addr;
  logic [BW-1:0]   we0_g, we1_g;
  logic [DW-1:0]   old0, old1, new0, new1;
  logic [DW-1:0]   rdat [2];
  logic [1:0]      rdv;
  logic [DW-1:0]   q_r [2];
  logic [1:0]      qv_r;

  // Replace the byte lanes selected by en with the matching lanes of wdata
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] base,
                                               input logic [DW-1:0] wdata,
                                               input logic [BW-1:0] en);
    lane_merge = base;
    for (int n = 0; n < BW; n++)
      if (en[n]) lane_merge[8*n +: 8] = wdata[8*n +: 8];
  endfunction

  assign busy = (st == CLEAR);

  // Clear engine next state: counter runs once over the array, clr restarts it
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      IDLE: begin
        if (clr) begin
          st_nxt  = CLEAR;
          cnt_nxt = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (clr)              cnt_nxt = '0;
        else if (cnt == LAST) st_nxt  = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Clear engine state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Port gating while busy, port-0 priority on shared lanes, read data selection
  always_comb begin
    same_addr = (addr0 == addr1);
    we0_g     = busy ? '0 : we0;
    we1_g     = busy ? '0 : we1;
    if (same_addr) we1_g = we1_g & ~we0_g;
    rdv       = {rd1 & ~busy, rd0 & ~busy};
    old0      = mem[addr0];
    old1      = mem[addr1];
    new0      = lane_merge(old0, data0, we0_g);
    new1      = lane_merge(old1, data1, we1_g);
    rdat[0]   = (RDW != 0) ? new0 : old0;
    rdat[1]   = (RDW != 0) ? new1 : old1;
  end

  // Array writes: clear engine when busy, otherwise both ports on disjoint lanes
  always_ff @(posedge clk) begin
    if (busy) begin
      if (rst_n) mem[cnt] <= CLRVAL;
    end else if (same_addr) begin
      if (|(we0_g | we1_g)) mem[addr0] <= lane_merge(new0, data1, we1_g);
    end else begin
      if (|we0_g) mem[addr0] <= new0;
      if (|we1_g) mem[addr1] <= new1;
    end
  end

  generate
    if (LAT == 2) begin : gen_lat2
      logic [DW-1:0] d_p1 [2];
      logic [1:0]    vld_p1;

      // Two-stage read pipe: data and valid advance together
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p1  <= '0;
          qv_r    <= '0;
          q_r[0]  <= '0;
          q_r[1]  <= '0;
        end else begin
          // stage p0 -> p1: capture accepted read word
          vld_p1 <= rdv;
          for (int p = 0; p < 2; p++)
            if (rdv[p]) d_p1[p] <= rdat[p];
          // stage p1 -> output
          qv_r <= vld_p1;
          for (int p = 0; p < 2; p++)
            if (vld_p1[p]) q_r[p] <= d_p1[p];
        end
      end
    end else begin : gen_lat1
      // Single-stage read: output register loads on accepted reads only
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          qv_r   <= '0;
          q_r[0] <= '0;
          q_r[1] <= '0;
        end else begin
          // stage p0 -> output
          qv_r <= rdv;
          for (int p = 0; p < 2; p++)
            if (rdv[p]) q_r[p] <= rdat[p];
        end
      end
    end
  endgenerate

  assign q0  = q_r[0];
  assign q1  = q_r[1];
  assign qv0 = qv_r[0];
  assign qv1 = qv_r[1];

endmodule

// File: tb/tb_jtframe_dual_ram_bclr.sv
// Bench for jtframe_dual_ram_bclr: two instances (LAT=1/RDW=0 and LAT=2/RDW=1)
// share one stimulus stream and are compared each cycle to a word-array model.
module tb_jtframe_dual_ram_bclr;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n, clr;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic [1:0]    we0, we1;
  logic          rd0, rd1;

  logic          busy_a, qva0, qva1, busy_b, qvb0, qvb1;
  logic [DW-1:0] qa0, qa1, qb0, qb1;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [DW-1:0] ref_mem [N];
  int            clr_left = 0;
  int            clr_addr = 0;
  logic [DW-1:0] ea_q [2];
  logic          ea_v [2];
  logic [DW-1:0] eb_q [2];
  logic          eb_v [2];
  logic [DW-1:0] pb_d [2];
  logic          pb_v [2];

  always #5 clk = ~clk;

  jtframe_dual_ram_bclr #(.DW(DW), .AW(AW), .LAT(1), .RDW(0), .CLR_ON_RST(1), .CLRVAL(16'h0000)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
    .addr0(addr0), .data0(data0), .we0(we0), .rd0(rd0), .q0(qa0), .qv0(qva0),
    .addr1(addr1), .data1(data1), .we1(we1), .rd1(rd1), .q1(qa1), .qv1(qva1));

  jtframe_dual_ram_bclr #(.DW(DW), .AW(AW), .LAT(2), .RDW(1), .CLR_ON_RST(1), .CLRVAL(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
    .addr0(addr0), .data0(data0), .we0(we0), .rd0(rd0), .q0(qb0), .qv0(qvb0),
    .addr1(addr1), .data1(data1), .we1(we1), .rd1(rd1), .q1(qb1), .qv1(qvb1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] put_lanes(input logic [DW-1:0] base,
                                              input logic [DW-1:0] wd,
                                              input logic [1:0] en);
    logic [DW-1:0] r;
    r = base;
    if (en[0]) r[7:0]  = wd[7:0];
    if (en[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  // One clock: update the model from the applied inputs, then compare all outputs
  task automatic tick;
    logic [DW-1:0] old [2];
    logic [DW-1:0] nw [2];
    logic [1:0]    acc;
    logic [1:0]    en1;
    @(posedge clk);
    if (!rst_n) begin
      clr_left = N;
      clr_addr = 0;
      for (int p = 0; p < 2; p++) begin
        ea_q[p] = '0; ea_v[p] = 1'b0;
        eb_q[p] = '0; eb_v[p] = 1'b0;
        pb_v[p] = 1'b0;
      end
    end else begin
      acc = 2'b00;
      old[0] = '0; old[1] = '0; nw[0] = '0; nw[1] = '0;
      if (clr_left > 0) begin
        ref_mem[clr_addr] = 16'h0000;
        if (clr) begin
          clr_addr = 0;
          clr_left = N;
        end else begin
          clr_addr++;
          clr_left--;
        end
      end else begin
        en1    = (addr0 == addr1) ? (we1 & ~we0) : we1;
        old[0] = ref_mem[addr0];
        old[1] = ref_mem[addr1];
        nw[0]  = put_lanes(old[0], data0, we0);
        nw[1]  = put_lanes(old[1], data1, en1);
        acc    = {rd1, rd0};
        ref_mem[addr0] = put_lanes(ref_mem[addr0], data0, we0);
        ref_mem[addr1] = put_lanes(ref_mem[addr1], data1, en1);
        if (clr) begin
          clr_left = N;
          clr_addr = 0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        ea_v[p] = acc[p];
        if (acc[p]) ea_q[p] = old[p];
        eb_v[p] = pb_v[p];
        if (pb_v[p]) eb_q[p] = pb_d[p];
        pb_v[p] = acc[p];
        if (acc[p]) pb_d[p] = nw[p];
      end
    end
    #1;
    chk("busy_a", busy_a, clr_left > 0);
    chk("busy_b", busy_b, clr_left > 0);
    chk("qa0", qa0, ea_q[0]);  chk("qva0", qva0, ea_v[0]);
    chk("qa1", qa1, ea_q[1]);  chk("qva1", qva1, ea_v[1]);
    chk("qb0", qb0, eb_q[0]);  chk("qvb0", qvb0, eb_v[0]);
    chk("qb1", qb1, eb_q[1]);  chk("qvb1", qvb1, eb_v[1]);
    rst_n = 1'b1; clr = 1'b0; we0 = 2'b00; we1 = 2'b00; rd0 = 1'b0; rd1 = 1'b0;
  endtask

  task automatic sweep(input bit expect_zero);
    for (int i = 0; i < N; i++) begin
      addr0 = 4'(i); addr1 = 4'(N - 1 - i); rd0 = 1'b1; rd1 = 1'b1;
      tick;
      if (expect_zero) begin
        chk("zero_a0", qa0, 16'h0000);
        chk("zero_a1", qa1, 16'h0000);
      end
    end
    tick;
    tick;
  endtask

  task automatic busy_span(input string tag);
    int cnt;
    cnt = 0;
    while (busy_a && cnt < 40) begin
      we0 = 2'b11; addr0 = 4'(9); data0 = 16'hFFFF; rd0 = 1'b1;
      tick;
      cnt++;
    end
    chk(tag, cnt, N);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    we0 = '0; we1 = '0; rd0 = 1'b0; rd1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      u_a.mem[i] = 16'($urandom);
      u_b.mem[i] = 16'($urandom);
      ref_mem[i] = 16'hxxxx;
    end

    // reset, automatic clear, all-zero readback
    rst_n = 1'b0; tick;
    chk("rst_qa0", qa0, 16'h0000);
    chk("rst_qvb0", qvb0, 1'b0);
    rst_n = 1'b0; tick;
    busy_span("clr_span_rst");
    sweep(1'b1);

    // byte-lane writes over an existing word
    addr0 = 4'd3; data0 = 16'h1234; we0 = 2'b11; tick;
    addr0 = 4'd3; data0 = 16'hABCD; we0 = 2'b01; tick;
    addr0 = 4'd3; rd0 = 1'b1; tick;
    chk("t2_lo_lane", qa0, 16'h12CD);
    addr0 = 4'd0; addr1 = 4'd3; data1 = 16'h5600; we1 = 2'b10; tick;
    addr0 = 4'd3; rd0 = 1'b1; tick;
    chk("t2_hi_lane", qa0, 16'h56CD);
    tick;
    chk("t2_hi_lane_b", qb0, 16'h56CD);

    // same-port read during write: old data (A) vs merged data (B)
    addr0 = 4'd5; data0 = 16'hBEEF; we0 = 2'b11; rd0 = 1'b1; tick;
    chk("t3_rdw_old", qa0, 16'h0000);
    tick;
    chk("t3_rdw_new", qb0, 16'hBEEF);

    // two-port collision on one address
    addr0 = 4'd7; data0 = 16'hCAFE; we0 = 2'b11; tick;
    addr0 = 4'd7; addr1 = 4'd7; data0 = 16'h0011; we0 = 2'b01;
    data1 = 16'h2233; we1 = 2'b11; rd1 = 1'b1; tick;
    chk("t4_rd_pre", qa1, 16'hCAFE);
    tick;
    addr0 = 4'd7; rd0 = 1'b1; tick;
    chk("t4_merge", qa0, 16'h2211);
    addr0 = 4'd7; data0 = 16'h1111; we0 = 2'b11; addr1 = 4'd7; rd1 = 1'b1; tick;
    chk("t4_cross_a", qa1, 16'h2211);
    tick;
    chk("t4_cross_b", qb1, 16'h2211);

    // back-to-back reads: latency 1 on A, latency 2 on B
    for (int i = 0; i < 3; i++) begin
      addr0 = 4'(i); data0 = 16'h1000 + 16'(i); we0 = 2'b11; tick;
    end
    for (int i = 0; i < 3; i++) begin
      addr0 = 4'(i); rd0 = 1'b1; tick;
      chk("t5_a_vld", qva0, 1'b1);
      chk("t5_a_data", qa0, 16'h1000 + 16'(i));
    end
    tick;
    chk("t5_b_last", qb0, 16'h1002);
    chk("t5_a_gap", qva0, 1'b0);
    tick;

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      addr0 = 4'($urandom_range(0, N - 1));
      addr1 = ($urandom_range(0, 3) == 0) ? addr0 : 4'($urandom_range(0, N - 1));
      data0 = 16'($urandom); data1 = 16'($urandom);
      we0 = 2'($urandom); we1 = 2'($urandom);
      rd0 = 1'($urandom); rd1 = 1'($urandom);
      tick;
    end
    sweep(1'b0);

    // clear request, restart mid-clear, reset mid-clear, writes while busy lost
    clr = 1'b1; tick;
    for (int k = 0; k < 10; k++) begin
      we0 = 2'b11; addr0 = 4'd9; data0 = 16'hFFFF; rd0 = 1'b1; tick;
    end
    clr = 1'b1; tick;
    for (int k = 0; k < 5; k++) begin
      we1 = 2'b11; addr1 = 4'd2; data1 = 16'hEEEE; tick;
    end
    rst_n = 1'b0; tick;
    busy_span("clr_span_abort");
    sweep(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
